cxu_mac: RTL and testbench

CXU_MAC -- requirements
Module: cxu_mac

---
 rtl/cxu_mac.sv | 142 ++++++++++++++
 tb/tb_cxu_mac.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cxu_mac.sv
// cxu_mac: custom-function MAC unit with N_STATES 32-bit accumulator contexts.
// Build option CXU_MAC_FAST_MUL_EN swaps the 32-cycle shift-add for a one-cycle multiplier.
module cxu_mac #(
  parameter int N_STATES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cxu_valid,
  input  logic [31:0] cxu_data0_i,
  input  logic [31:0] cxu_data1_i,
  input  logic [1:0]  cx_state_id_i,
  input  logic [2:0]  cx_func_i,
  output logic        cxu_ready,
  output logic [31:0] cxu_response,
  output logic [3:0]  cxu_status
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] F_MUL   = 3'd0;
  localparam logic [2:0] F_MAC   = 3'd1;
  localparam logic [2:0] F_WRITE = 3'd3;
  localparam logic [2:0] F_CLEAR = 3'd4;

  state_t      state;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [2:0]  func_r;
  logic [1:0]  sid_r;
  logic [31:0] acc [4];
  logic [63:0] product;
  logic [31:0] acc_sel;
  logic [32:0] mac_sum;
  logic        illegal;
  logic        hi_nz;

`ifdef CXU_MAC_FAST_MUL_EN
  assign product = {32'b0, a_r} * {32'b0, b_r};
`else
  logic [63:0] prod_r;
  logic [63:0] mcand_r;
  logic [4:0]  cnt_r;
  logic        in_illegal;
  logic        start_mul;

  assign in_illegal = (cx_func_i > F_CLEAR) || (int'(cx_state_id_i) >= N_STATES);
  assign start_mul  = !in_illegal && (cx_func_i <= F_MAC);
  assign product    = prod_r;
`endif

  assign illegal = (func_r > F_CLEAR) || (int'(sid_r) >= N_STATES);
  assign acc_sel = acc[sid_r];
  assign mac_sum = {1'b0, acc_sel} + {1'b0, product[31:0]};
  assign hi_nz   = |product[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      func_r <= '0;
      sid_r  <= '0;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
`ifndef CXU_MAC_FAST_MUL_EN
      prod_r  <= '0;
      mcand_r <= '0;
      cnt_r   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cxu_valid) begin
            a_r    <= cxu_data0_i;
            b_r    <= cxu_data1_i;
            func_r <= cx_func_i;
            sid_r  <= cx_state_id_i;
`ifdef CXU_MAC_FAST_MUL_EN
            state  <= DONE;
`else
            prod_r  <= '0;
            mcand_r <= {32'b0, cxu_data0_i};
            cnt_r   <= 5'd31;
            state   <= start_mul ? BUSY : DONE;
`endif
          end
        end
`ifndef CXU_MAC_FAST_MUL_EN
        // b_r doubles as the multiplier shift register; a_r keeps data0 for WRITE
        BUSY: begin
          if (!cxu_valid) begin
            state <= IDLE;
          end else begin
            if (b_r[0]) prod_r <= prod_r + mcand_r;
            mcand_r <= mcand_r << 1;
            b_r     <= b_r >> 1;
            if (cnt_r == 5'd0) state <= DONE;
            else cnt_r <= cnt_r - 5'd1;
          end
        end
`endif
        DONE: begin
          if (!illegal) begin
            case (func_r)
              F_MAC:   acc[sid_r] <= mac_sum[31:0];
              F_WRITE: acc[sid_r] <= a_r;
              F_CLEAR: acc[sid_r] <= '0;
              default: ;
            endcase
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cxu_ready    = 1'b0;
    cxu_response = '0;
    cxu_status   = '0;
    if (state == DONE) begin
      cxu_ready = 1'b1;
      if (illegal) begin
        cxu_status[0] = 1'b1;
      end else begin
        case (func_r)
          F_MUL: begin
            cxu_response  = product[31:0];
            cxu_status[2] = hi_nz;
          end
          F_MAC: begin
            cxu_response  = mac_sum[31:0];
            cxu_status[1] = mac_sum[32];
            cxu_status[2] = hi_nz;
          end
          default: cxu_response = acc_sel;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cxu_mac.sv
// tb_cxu_mac: directed table, corner sequences and random traffic against an arithmetic model.
// Two instances share stimulus: N_STATES=4 (main) and N_STATES=2 (context-range checks).
module tb_cxu_mac;

`ifdef CXU_MAC_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] d0 = '0, d1 = '0;
  logic [1:0]  sid = '0;
  logic [2:0]  func = '0;
  logic        rdy, rdy2;
  logic [31:0] rsp, rsp2;
  logic [3:0]  sts, sts2;

  int pass_cnt = 0;
  int total = 0;
  logic [31:0] acc_m [2][4];
  logic [31:0] last_r2;
  logic [3:0]  last_s2;
  int          last_lat2;

  always #5 clk = ~clk;

  cxu_mac #(.N_STATES(4)) dut (
    .clk(clk), .rst(rst), .cxu_valid(valid), .cxu_data0_i(d0), .cxu_data1_i(d1),
    .cx_state_id_i(sid), .cx_func_i(func), .cxu_ready(rdy), .cxu_response(rsp), .cxu_status(sts)
  );

  cxu_mac #(.N_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .cxu_valid(valid), .cxu_data0_i(d0), .cxu_data1_i(d1),
    .cx_state_id_i(sid), .cx_func_i(func), .cxu_ready(rdy2), .cxu_response(rsp2), .cxu_status(sts2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 4; i++) acc_m[w][i] = '0;
  endfunction

  // w=0 models the N_STATES=4 instance, w=1 the N_STATES=2 instance
  function automatic void model(input int w, input logic [2:0] f, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] stx, output int lat);
    int ns;
    logic [63:0] p;
    logic [32:0] sum;
    ns  = (w != 0) ? 2 : 4;
    p   = {32'b0, a} * {32'b0, b};
    r   = '0;
    stx = '0;
    lat = 1;
    if (f > 3'd4 || int'(s) >= ns) begin
      stx = 4'h1;
      return;
    end
    case (f)
      3'd0: begin
        r = p[31:0];
        stx[2] = (p[63:32] != 0);
        lat = MUL_LAT;
      end
      3'd1: begin
        sum = {1'b0, acc_m[w][s]} + {1'b0, p[31:0]};
        r = sum[31:0];
        stx[1] = sum[32];
        stx[2] = (p[63:32] != 0);
        acc_m[w][s] = sum[31:0];
        lat = MUL_LAT;
      end
      3'd2: r = acc_m[w][s];
      3'd3: begin r = acc_m[w][s]; acc_m[w][s] = a; end
      default: begin r = acc_m[w][s]; acc_m[w][s] = '0; end
    endcase
  endfunction

  // Call at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_req(input logic [2:0] f, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r, output logic [3:0] stx);
    int lat, el, el2;
    logic seen2, quiet;
    logic [31:0] er, er2;
    logic [3:0] es, es2;
    func = f; sid = s; d0 = a; d1 = b; valid = 1'b1;
    @(posedge clk);
    lat = 0; seen2 = 1'b0; quiet = 1'b1;
    last_r2 = '0; last_s2 = '0; last_lat2 = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (rdy2 && !seen2) begin
        seen2 = 1'b1; last_lat2 = lat; last_r2 = rsp2; last_s2 = sts2;
      end
      if (rdy) break;
      if (rsp != 0 || sts != 0) quiet = 1'b0;
    end
    r = rsp; stx = sts;
    valid = 1'b0;
    @(negedge clk);
    model(0, f, s, a, b, er, es, el);
    model(1, f, s, a, b, er2, es2, el2);
    check("response", r, er);
    check("status", stx, es);
    check("latency", lat, el);
    check("idle_outputs_zero", quiet, 1'b1);
    check("n2_response", last_r2, er2);
    check("n2_status", last_s2, es2);
    check("n2_latency", last_lat2, el2);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic [3:0]  es;
  } vec_t;

  vec_t vt [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  stx;
    logic [2:0]  rf;
    logic [1:0]  rs;
    logic [31:0] ra, rb;
    logic        seen;

    vt[0]  = '{3'd0, 2'd0, 32'd7,        32'd6,       32'd42,       4'h0};
    vt[1]  = '{3'd3, 2'd1, 32'hFFFFFFF0, 32'd0,       32'd0,        4'h0};
    vt[2]  = '{3'd1, 2'd1, 32'd4,        32'd5,       32'h00000004, 4'h2};
    vt[3]  = '{3'd2, 2'd1, 32'd0,        32'd0,       32'd4,        4'h0};
    vt[4]  = '{3'd0, 2'd0, 32'h10000,    32'h10000,   32'd0,        4'h4};
    vt[5]  = '{3'd6, 2'd0, 32'd9,        32'd9,       32'd0,        4'h1};
    vt[6]  = '{3'd2, 2'd3, 32'd0,        32'd0,       32'd0,        4'h0};
    vt[7]  = '{3'd4, 2'd1, 32'd0,        32'd0,       32'd4,        4'h0};
    vt[8]  = '{3'd2, 2'd1, 32'd0,        32'd0,       32'd0,        4'h0};
    vt[9]  = '{3'd3, 2'd3, 32'h0000ABCD, 32'd0,       32'd0,        4'h0};
    vt[10] = '{3'd2, 2'd3, 32'd0,        32'd0,       32'h0000ABCD, 4'h0};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", {rdy, rsp, sts}, '0);

    // first request issued in the very cycle reset drops
    rst = 1'b0;
    run_req(3'd2, 2'd0, 32'd0, 32'd0, r, stx);

    for (int i = 0; i < 11; i++) begin
      run_req(vt[i].f, vt[i].s, vt[i].a, vt[i].b, r, stx);
      check($sformatf("table%0d_response", i), r, vt[i].er);
      check($sformatf("table%0d_status", i), stx, vt[i].es);
      if (i == 6) begin
        check("n2_ctx3_response", last_r2, 32'd0);
        check("n2_ctx3_status", last_s2, 4'h1);
        check("n2_ctx3_latency", last_lat2, 1);
      end
    end

`ifndef CXU_MAC_FAST_MUL_EN
    // valid withdrawn at BUSY cycle 10: no pulse, no commit
    run_req(3'd3, 2'd2, 32'h100, 32'd0, r, stx);
    func = 3'd1; sid = 2'd2; d0 = 32'd3; d1 = 32'd5; valid = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= rdy;
    end
    valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= rdy;
    end
    check("abort_no_ready", seen, 1'b0);
    run_req(3'd2, 2'd2, 32'd0, 32'd0, r, stx);
    check("abort_acc_kept", r, 32'h100);
`endif

    // reset during an in-flight MAC discards it and clears all contexts
    run_req(3'd3, 2'd0, 32'h55, 32'd0, r, stx);
    func = 3'd1; sid = 2'd0; d0 = 32'd2; d1 = 32'd3; valid = 1'b1;
    @(posedge clk);
    repeat ((MUL_LAT > 1) ? 5 : 1) @(negedge clk);
    rst = 1'b1;
    valid = 1'b0;
    #1;
    check("reset_mid_op_outputs", {rdy, rsp, sts}, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_req(3'd2, 2'd0, 32'd0, 32'd0, r, stx);
    check("reset_ctx0_cleared", r, 32'd0);

    for (int i = 0; i < 60; i++) begin
      rf = 3'($urandom_range(0, 7));
      rs = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: ra = $urandom;
        1: ra = 32'($urandom_range(0, 255));
        default: ra = 32'hFFFF0000 | 32'($urandom_range(0, 65535));
      endcase
      case ($urandom_range(0, 2))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(0, 255));
        default: rb = 32'hFFFF0000 | 32'($urandom_range(0, 65535));
      endcase
      run_req(rf, rs, ra, rb, r, stx);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
